// File: rtl/mod_exp_pkg.sv
// Shared encodings and defaults for the modular-exponentiation controller.
package mod_exp_pkg;

  localparam int unsigned K_DEF     = 192;
  localparam int unsigned EW_DEF    = 192;
  localparam int unsigned LOGEW_DEF = 8;

  // Top-level sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TO_MONT   = 3'd1,
    ST_SQUARE    = 3'd2,
    ST_MULT      = 3'd3,
    ST_FROM_MONT = 3'd4,
    ST_FIN       = 3'd5
  } top_state_t;

  // Multiplier handshake states, one pass per Montgomery product.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_PREP  = 2'd1,
    OP_ISSUE = 2'd2,
    OP_WAIT  = 2'd3
  } op_state_t;

  // Operand pair presented to the multiplier.
  typedef enum logic [1:0] {
    SEL_BASE_R2  = 2'd0,
    SEL_ACC_ACC  = 2'd1,
    SEL_ACC_BASE = 2'd2,
    SEL_ACC_ONE  = 2'd3
  } op_sel_t;

  // States that own a multiplier operation.
  function automatic logic is_op_state(input top_state_t s);
    return (s == ST_TO_MONT) || (s == ST_SQUARE) || (s == ST_MULT) || (s == ST_FROM_MONT);
  endfunction

  // Operand pair used by each operation state.
  function automatic op_sel_t sel_for_state(input top_state_t s);
    op_sel_t sel;
    sel = SEL_ACC_ACC;
    case (s)
      ST_TO_MONT:   sel = SEL_BASE_R2;
      ST_SQUARE:    sel = SEL_ACC_ACC;
      ST_MULT:      sel = SEL_ACC_BASE;
      ST_FROM_MONT: sel = SEL_ACC_ONE;
      default:      sel = SEL_ACC_ACC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_op_seq.sv
// PREP/ISSUE/WAIT handshake with the shared Montgomery multiplier.
// A go in OP_IDLE starts one product; capture marks the cycle mm_z is valid.
module mm_op_seq
  import mod_exp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic mm_done,
  output logic mm_start,
  output logic capture,
  output logic ready
);

  op_state_t state;
  op_state_t state_nxt;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= OP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one PREP cycle with start low, hold start until the
  // multiplier drops done, then wait for done to come back.
  always_comb begin
    state_nxt = state;
    unique case (state)
      OP_IDLE:  if (go)       state_nxt = OP_PREP;
      OP_PREP:                state_nxt = OP_ISSUE;
      OP_ISSUE: if (!mm_done) state_nxt = OP_WAIT;
      OP_WAIT:  if (mm_done)  state_nxt = OP_IDLE;
      default:                state_nxt = OP_IDLE;
    endcase
  end

  // Moore-style handshake outputs.
  always_comb begin
    mm_start = 1'b0;
    capture  = 1'b0;
    ready    = 1'b0;
    unique case (state)
      OP_IDLE:  ready    = 1'b1;
      OP_PREP:  mm_start = 1'b0;
      OP_ISSUE: mm_start = 1'b1;
      OP_WAIT:  capture  = mm_done;
      default:  ready    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller around one shared
// Montgomery multiplier: result = base^exp mod m.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int unsigned K     = K_DEF,
  parameter int unsigned EW    = EW_DEF,
  parameter int unsigned LOGEW = LOGEW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [K-1:0]  base,
  input  logic [EW-1:0] exp,
  input  logic [K-1:0]  r2_mod_m,
  input  logic [K-1:0]  one_mont,
  output logic          busy,
  output logic          done,
  output logic [K-1:0]  result,
  output logic          mm_start,
  output logic [K-1:0]  mm_x,
  output logic [K-1:0]  mm_y,
  input  logic          mm_done,
  input  logic [K-1:0]  mm_z
);

  top_state_t     state;
  top_state_t     state_nxt;

  logic [EW-1:0]  exp_q;
  logic [K-1:0]   base_q;
  logic [K-1:0]   base_m;
  logic [K-1:0]   acc;
  logic [LOGEW-1:0] idx;

  logic           op_go;
  logic           op_ready;
  logic           op_capture;
  op_sel_t        op_sel;
  logic [K-1:0]   x_mux;
  logic [K-1:0]   y_mux;

  logic [EW-1:0]  exp_sh;
  logic           cur_bit;
  logic           idx_zero;

  mm_op_seq u_op_seq (
    .clk      (clk),
    .reset    (reset),
    .go       (op_go),
    .mm_done  (mm_done),
    .mm_start (mm_start),
    .capture  (op_capture),
    .ready    (op_ready)
  );

  // Exponent bit under scan and end-of-scan flag.
  always_comb begin
    exp_sh   = exp_q >> idx;
    cur_bit  = exp_sh[0];
    idx_zero = (idx == '0);
  end

  // Top state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Top next-state: advance only on a captured product.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_TO_MONT;
      end
      ST_TO_MONT: begin
        if (op_capture) state_nxt = ST_SQUARE;
      end
      ST_SQUARE: begin
        if (op_capture) begin
          if (cur_bit)       state_nxt = ST_MULT;
          else if (idx_zero) state_nxt = ST_FROM_MONT;
          else               state_nxt = ST_SQUARE;
        end
      end
      ST_MULT: begin
        if (op_capture) state_nxt = idx_zero ? ST_FROM_MONT : ST_SQUARE;
      end
      ST_FROM_MONT: begin
        if (op_capture) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Top outputs: status, operation launch and operand selection.
  // A new product is launched whenever an operation state finds the
  // sequencer idle, so a SQUARE->SQUARE step relaunches automatically.
  always_comb begin
    busy   = (state != ST_IDLE) && (state != ST_FIN);
    done   = (state == ST_FIN);
    op_go  = is_op_state(state) && op_ready;
    op_sel = sel_for_state(state);
  end

  // Operand mux feeding the registered multiplier inputs.
  always_comb begin
    x_mux = acc;
    y_mux = acc;
    unique case (op_sel)
      SEL_BASE_R2: begin
        x_mux = base_q;
        y_mux = r2_mod_m;
      end
      SEL_ACC_ACC: begin
        x_mux = acc;
        y_mux = acc;
      end
      SEL_ACC_BASE: begin
        x_mux = acc;
        y_mux = base_m;
      end
      SEL_ACC_ONE: begin
        x_mux = acc;
        y_mux = K'(1);
      end
      default: begin
        x_mux = acc;
        y_mux = acc;
      end
    endcase
  end

  // Datapath: operand latch, multiplier operand registers, accumulator,
  // Montgomery base, bit index and result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q  <= '0;
      base_q <= '0;
      base_m <= '0;
      acc    <= '0;
      idx    <= '0;
      mm_x   <= '0;
      mm_y   <= '0;
      result <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        exp_q  <= exp;
        base_q <= base;
        acc    <= one_mont;
        idx    <= LOGEW'(EW - 1);
      end

      // Operands load on entry to PREP and hold until the product is captured.
      if (op_go) begin
        mm_x <= x_mux;
        mm_y <= y_mux;
      end

      if (op_capture) begin
        unique case (state)
          ST_TO_MONT: begin
            base_m <= mm_z;
          end
          ST_SQUARE: begin
            acc <= mm_z;
            // A set bit keeps the index for the following MULT.
            if (!cur_bit && !idx_zero) idx <= idx - 1'b1;
          end
          ST_MULT: begin
            acc <= mm_z;
            if (!idx_zero) idx <= idx - 1'b1;
          end
          ST_FROM_MONT: begin
            result <= mm_z;
          end
          default: begin
            acc <= acc;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl paired with a behavioural P-192
// Montgomery multiplier.
module tb_mod_exp_ctrl;

  localparam int unsigned K      = 192;
  localparam int unsigned EW     = 192;
  localparam int unsigned MM_LAT = 3;

  localparam logic [K-1:0] P     = 192'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF;
  localparam logic [K-1:0] ONE_M = 192'h0000000000000000_0000000000000001_0000000000000001;
  localparam logic [K-1:0] R2_M  = 192'h0000000000000001_0000000000000002_0000000000000001;

  logic          clk;
  logic          reset;
  logic          start;
  logic [K-1:0]  base;
  logic [EW-1:0] exp;
  logic [K-1:0]  r2_mod_m;
  logic [K-1:0]  one_mont;
  logic          busy;
  logic          done;
  logic [K-1:0]  result;
  logic          mm_start;
  logic [K-1:0]  mm_x;
  logic [K-1:0]  mm_y;
  logic          mm_done;
  logic [K-1:0]  mm_z;

  int vectors;
  int miscompares;
  int op_cnt;
  int done_cnt;

  mod_exp_ctrl #(.K(K), .EW(EW), .LOGEW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exp      (exp),
    .r2_mod_m (r2_mod_m),
    .one_mont (one_mont),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mm_start (mm_start),
    .mm_x     (mm_x),
    .mm_y     (mm_y),
    .mm_done  (mm_done),
    .mm_z     (mm_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x*y*2^-K mod P, bit-serial.
  function automatic logic [K-1:0] mont(input logic [K-1:0] x, input logic [K-1:0] y);
    logic [K+1:0] a;
    a = '0;
    for (int i = 0; i < K; i++) begin
      if (x[i]) a = a + {2'b00, y};
      if (a[0]) a = a + {2'b00, P};
      a = a >> 1;
    end
    if (a >= {2'b00, P}) a = a - {2'b00, P};
    return a[K-1:0];
  endfunction

  // Plain a*b mod P by double-and-add.
  function automatic logic [K-1:0] mulmod(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [K+1:0] r;
    r = '0;
    for (int i = K - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {2'b00, P}) r = r - {2'b00, P};
      if (b[i]) begin
        r = r + {2'b00, a};
        if (r >= {2'b00, P}) r = r - {2'b00, P};
      end
    end
    return r[K-1:0];
  endfunction

  // Right-to-left reference exponentiation.
  function automatic logic [K-1:0] modexp_ref(input logic [K-1:0] b, input logic [EW-1:0] e);
    logic [K-1:0] res;
    logic [K-1:0] bb;
    res = K'(1);
    bb  = b;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) res = mulmod(res, bb);
      bb = mulmod(bb, bb);
    end
    return res;
  endfunction

  // Behavioural multiplier: done high when idle, low for MM_LAT cycles
  // after an accepted start, then high with z; needs start low to re-arm.
  logic [1:0] mm_st;
  int         mm_cnt;
  always @(posedge clk) begin
    if (!reset) begin
      mm_st   <= 2'd0;
      mm_done <= 1'b1;
      mm_z    <= '0;
      mm_cnt  <= 0;
    end else begin
      case (mm_st)
        2'd0: if (mm_start) begin
          mm_done <= 1'b0;
          mm_cnt  <= MM_LAT;
          mm_st   <= 2'd1;
        end
        2'd1: if (mm_cnt == 1) begin
          mm_z    <= mont(mm_x, mm_y);
          mm_done <= 1'b1;
          mm_st   <= 2'd2;
        end else begin
          mm_cnt <= mm_cnt - 1;
        end
        default: if (!mm_start) mm_st <= 2'd0;
      endcase
    end
  end

  // Accepted multiplier operations and done pulses.
  initial op_cnt = 0;
  initial done_cnt = 0;
  always @(posedge clk) begin
    if (reset && (mm_st == 2'd0) && mm_start) op_cnt <= op_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic kick(input logic [K-1:0] b, input logic [EW-1:0] e);
    @(negedge clk);
    base  = b;
    exp   = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timeout, output bit busy_ok);
    timeout = 1'b1;
    busy_ok = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  int ops0;
  int dn0;
  bit tmo;
  bit bok;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    base        = '0;
    exp         = '0;
    r2_mod_m    = R2_M;
    one_mont    = ONE_M;
    repeat (3) @(negedge clk);

    chk("rst_busy",     K'(busy),     K'(0));
    chk("rst_done",     K'(done),     K'(0));
    chk("rst_result",   result,       K'(0));
    chk("rst_mm_start", K'(mm_start), K'(0));
    chk("rst_mm_x",     mm_x,         K'(0));
    chk("rst_mm_y",     mm_y,         K'(0));

    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1. exp=0 -> 1, 194 ops, single done pulse
    ops0 = op_cnt; dn0 = done_cnt;
    kick(K'(7), EW'(0));
    chk("t1_busy_after_start", K'(busy), K'(1));
    wait_done(tmo, bok);
    chk("t1_timeout", K'(tmo), K'(0));
    chk("t1_busy_at_done", K'(busy), K'(0));
    chk("t1_result", result, K'(1));
    repeat (3) @(negedge clk);
    chk("t1_done_pulses", K'(done_cnt - dn0), K'(1));
    chk("t1_ops", K'(op_cnt - ops0), K'(194));
    chk("t1_result_hold", result, K'(1));

    // 2. small exponents
    kick(K'(5), EW'(1));
    wait_done(tmo, bok);
    chk("t2a_timeout", K'(tmo), K'(0));
    chk("t2a_result", result, K'(5));
    kick(K'(3), EW'(2));
    wait_done(tmo, bok);
    chk("t2b_timeout", K'(tmo), K'(0));
    chk("t2b_result", result, K'(9));

    // 3. Fermat: 2^(p-1) mod p = 1, busy throughout, 2+192+190 ops
    ops0 = op_cnt;
    kick(K'(2), P - K'(1));
    wait_done(tmo, bok);
    chk("t3_timeout", K'(tmo), K'(0));
    chk("t3_result", result, K'(1));
    chk("t3_busy_whole_run", K'(bok), K'(1));
    chk("t3_ops", K'(op_cnt - ops0), K'(384));

    // 4. exp=0x10001 against the reference model
    ops0 = op_cnt;
    kick(K'(32'h1234), EW'(32'h10001));
    wait_done(tmo, bok);
    chk("t4_timeout", K'(tmo), K'(0));
    chk("t4_result", result, modexp_ref(K'(32'h1234), EW'(32'h10001)));
    chk("t4_ops", K'(op_cnt - ops0), K'(196));

    // base=0 with nonzero exponent
    kick(K'(0), EW'(5));
    wait_done(tmo, bok);
    chk("t4z_timeout", K'(tmo), K'(0));
    chk("t4z_result", result, K'(0));

    // 5. second start while busy is ignored
    ops0 = op_cnt;
    kick(K'(3), EW'(2));
    repeat (60) @(negedge clk);
    kick(K'(5), EW'(7));
    wait_done(tmo, bok);
    chk("t5_timeout", K'(tmo), K'(0));
    chk("t5_result", result, K'(9));
    chk("t5_ops", K'(op_cnt - ops0), K'(195));
    chk("t5_busy_whole_run", K'(bok), K'(1));

    // 6. reset mid-SQUARE aborts immediately
    ops0 = op_cnt;
    kick(K'(32'h1234), EW'(32'h10001));
    for (int c = 0; c < 5000 && (op_cnt - ops0) < 10; c++) @(negedge clk);
    chk("t6_reached_square", K'((op_cnt - ops0) >= 10), K'(1));
    reset = 1'b0;
    #1;
    chk("t6_rst_busy",     K'(busy),     K'(0));
    chk("t6_rst_mm_start", K'(mm_start), K'(0));
    chk("t6_rst_result",   result,       K'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    kick(K'(2), EW'(3));
    wait_done(tmo, bok);
    chk("t6_timeout", K'(tmo), K'(0));
    chk("t6_result", result, K'(8));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
